// File: rtl/seq_101_gen.sv
// seq_101_gen: serial "101" pattern source for the EGO1 sequence-detector lab.
// Loads a WIDTH-bit pattern and shifts it out MSB-first. Each bit is held for
// DIV clocks. A start/busy/done handshake controls each frame. An overlapping
// "101" reference counter gives a golden result for the detector under test.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; x=0, busy=0
// SHIFT | frame in progress; x shows sreg MSB, prescaler paces each bit
// DONE  | one-cycle frame tail; busy=0, ref_z cleared on exit

module seq_101_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50_000_000,
    parameter int CNT_W = 4
) (
    input  logic             cp,
    input  logic             rd,
    input  logic             start,
    input  logic             rep,
    input  logic [WIDTH-1:0] pattern,
    output logic             x,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             ref_z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state,     state_n;
    logic [WIDTH-1:0] sreg,      sreg_n;
    logic [PW-1:0]    pre,       pre_n;
    logic [IW-1:0]    idx,       idx_n;
    logic [1:0]       hist,      hist_n;
    logic             done_n;
    logic             ref_z_n;
    logic [CNT_W-1:0] match_cnt_n;

    logic tick;
    logic hit;

    assign busy      = (state == SHIFT);
    assign x         = busy & sreg[WIDTH-1];
    assign tick      = (pre == PRE_MAX);
    assign bit_valid = busy & tick;
    // Overlapping match: previous two emitted bits were "10" and this bit is 1.
    assign hit       = (hist == 2'b10) & sreg[WIDTH-1];

    // State and datapath registers; reset overrides any other event at the edge.
    always_ff @(posedge cp) begin
        if (rd) begin
            state     <= IDLE;
            sreg      <= '0;
            pre       <= '0;
            idx       <= '0;
            hist      <= 2'b00;
            done      <= 1'b0;
            ref_z     <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            pre       <= pre_n;
            idx       <= idx_n;
            hist      <= hist_n;
            done      <= done_n;
            ref_z     <= ref_z_n;
            match_cnt <= match_cnt_n;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        pre_n       = pre;
        idx_n       = idx;
        hist_n      = hist;
        done_n      = 1'b0;
        ref_z_n     = ref_z;
        match_cnt_n = match_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    sreg_n      = pattern;
                    pre_n       = '0;
                    idx_n       = '0;
                    hist_n      = 2'b00;
                    match_cnt_n = '0;
                    state_n     = SHIFT;
                end
            end

            SHIFT: begin
                if (tick) begin
                    pre_n   = '0;
                    hist_n  = {hist[0], sreg[WIDTH-1]};
                    ref_z_n = hit;
                    // The counter saturates at all-ones so it never wraps back to a small value.
                    if (hit && (match_cnt != {CNT_W{1'b1}}))
                        match_cnt_n = match_cnt + 1'b1;
                    sreg_n = sreg << 1;
                    idx_n  = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        done_n = 1'b1;
                        // In repeat mode the next frame starts with no gap.
                        // history and match_cnt carry over, so matches that span frames are counted.
                        if (rep) begin
                            sreg_n = pattern;
                            idx_n  = '0;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end else begin
                    pre_n = pre + 1'b1;
                end
            end

            DONE: begin
                ref_z_n = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_101_gen.sv
// Directed bench for seq_101_gen (WIDTH=8, DIV=4). A second instance uses CNT_W=2
// to exercise match_cnt saturation.

module tb_seq_101_gen;

    logic       cp = 1'b0;
    logic       rd;
    logic       start;
    logic       start2;
    logic       rep;
    logic [7:0] pattern;

    logic       x, bit_valid, busy, done, ref_z;
    logic [3:0] match_cnt;
    logic       x2, bit_valid2, busy2, done2, ref_z2;
    logic [1:0] match_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    seq_101_gen #(.WIDTH(8), .DIV(4), .CNT_W(4)) dut (
        .cp(cp), .rd(rd), .start(start), .rep(rep), .pattern(pattern),
        .x(x), .bit_valid(bit_valid), .busy(busy), .done(done),
        .ref_z(ref_z), .match_cnt(match_cnt)
    );

    seq_101_gen #(.WIDTH(8), .DIV(4), .CNT_W(2)) dut2 (
        .cp(cp), .rd(rd), .start(start2), .rep(rep), .pattern(pattern),
        .x(x2), .bit_valid(bit_valid2), .busy(busy2), .done(done2),
        .ref_z(ref_z2), .match_cnt(match_cnt2)
    );

    // Free-running system clock.
    always #5 cp = ~cp;

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One rep=0 frame on dut. exp_ref holds the hand-computed ref_z value after each bit, MSB = bit 1.
    task automatic run_frame(input logic [7:0] pat, input logic [7:0] exp_ref, input int exp_final);
        int cnt;
        int k;
        cnt     = 0;
        pattern = pat;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk("frame_x",     int'(x),         int'(pat[7 - c/4]));
            chk("frame_bv",    int'(bit_valid), int'(c % 4 == 3));
            chk("frame_busy",  int'(busy),      1);
            chk("frame_done",  int'(done),      0);
            if (c >= 4 && c % 4 == 0) begin
                k = c/4 - 1;
                if (exp_ref[7 - k]) cnt++;
                chk("frame_ref_z", int'(ref_z),     int'(exp_ref[7 - k]));
                chk("frame_cnt",   int'(match_cnt), cnt);
            end
            step();
        end
        chk("end_done",  int'(done),      1);
        chk("end_busy",  int'(busy),      0);
        chk("end_x",     int'(x),         0);
        chk("end_ref_z", int'(ref_z),     int'(exp_ref[0]));
        chk("end_cnt",   int'(match_cnt), exp_final);
        step();
        chk("idle_done",  int'(done),      0);
        chk("idle_busy",  int'(busy),      0);
        chk("idle_ref_z", int'(ref_z),     0);
        chk("idle_cnt",   int'(match_cnt), exp_final);
    endtask

    // Directed scenarios.
    initial begin
        logic [7:0] p;
        rd      = 1'b1;
        start   = 1'b1;
        start2  = 1'b0;
        rep     = 1'b0;
        pattern = 8'hFF;

        // Reset held 2 cycles with start asserted.
        step();
        step();
        chk("rst_x",    int'(x),         0);
        chk("rst_bv",   int'(bit_valid), 0);
        chk("rst_busy", int'(busy),      0);
        chk("rst_done", int'(done),      0);
        chk("rst_ref",  int'(ref_z),     0);
        chk("rst_cnt",  int'(match_cnt), 0);
        chk("rst_cnt2", int'(match_cnt2), 0);
        rd    = 1'b0;
        start = 1'b0;
        step();
        step();
        step();
        chk("post_rst_busy", int'(busy), 0);

        // 1010_0101: matches after bits 3 and 8.
        run_frame(8'b1010_0101, 8'b0010_0001, 2);
        // 1010_1010: overlapping matches after bits 3, 5, 7.
        run_frame(8'b1010_1010, 8'b0010_1010, 3);

        // Repeat mode, two frames of 1000_0010: only the boundary "10|1" matches.
        p       = 8'b1000_0010;
        pattern = p;
        rep     = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            chk("rep_busy", int'(busy), 1);
            chk("rep_done", int'(done), int'(c == 32));
            chk("rep_x",    int'(x),    int'(p[7 - (c % 32)/4]));
            if (c == 32) chk("rep_cnt_f1", int'(match_cnt), 0);
            if (c == 36) begin
                chk("rep_cnt_boundary", int'(match_cnt), 1);
                chk("rep_ref_boundary", int'(ref_z),     1);
            end
            if (c == 33) rep = 1'b0;
            step();
        end
        chk("rep_end_done", int'(done),      1);
        chk("rep_end_busy", int'(busy),      0);
        chk("rep_end_cnt",  int'(match_cnt), 1);
        step();
        chk("rep_idle_done", int'(done), 0);

        // Mid-frame start and pattern change are ignored; reset during bit 4 aborts the frame.
        p       = 8'b1010_0101;
        pattern = p;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            chk("mid_x",    int'(x),         int'(p[7 - c/4]));
            chk("mid_bv",   int'(bit_valid), int'(c % 4 == 3));
            chk("mid_busy", int'(busy),      1);
            if (c == 12) chk("mid_cnt", int'(match_cnt), 1);
            if (c == 2) pattern = 8'h00;
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (c == 13) rd = 1'b1;
            step();
        end
        chk("abort_x",    int'(x),         0);
        chk("abort_busy", int'(busy),      0);
        chk("abort_cnt",  int'(match_cnt), 0);
        chk("abort_ref",  int'(ref_z),     0);
        chk("abort_bv",   int'(bit_valid), 0);
        chk("abort_done", int'(done),      0);
        rd = 1'b0;
        step();
        run_frame(8'b1010_1010, 8'b0010_1010, 3);

        // CNT_W=2 instance: 1010_1010 repeated twice saturates at 3.
        p       = 8'b1010_1010;
        pattern = p;
        rep     = 1'b1;
        start2  = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 0; c < 64; c++) begin
            chk("sat_busy", int'(busy2), 1);
            chk("sat_done", int'(done2), int'(c == 32));
            chk("sat_x",    int'(x2),    int'(p[7 - (c % 32)/4]));
            if (c == 0)  chk("sat_cnt_start", int'(match_cnt2), 0);
            if (c == 24) chk("sat_cnt_b6",    int'(match_cnt2), 2);
            if (c == 32) chk("sat_cnt_f1",    int'(match_cnt2), 3);
            if (c == 36) begin
                chk("sat_cnt_boundary", int'(match_cnt2), 3);
                chk("sat_ref_boundary", int'(ref_z2),     1);
            end
            if (c == 33) rep = 1'b0;
            step();
        end
        chk("sat_end_done", int'(done2),      1);
        chk("sat_end_busy", int'(busy2),      0);
        chk("sat_end_cnt",  int'(match_cnt2), 3);
        chk("sat_dut1_idle", int'(busy),      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
